// File: rtl/da_idct_pkg.sv
// Shared definitions for the bit-serial DA 8-point inverse DCT: word widths,
// the cosine constant table, the DA ROM contents and the round/saturate step.
package da_idct_pkg;

   localparam int IN_WORD_SIZE  = 26;   // signed coefficient width
   localparam int OUT_WORD_SIZE = 10;   // signed sample width
   localparam int IN_FRAC       = 12;   // fractional bits of the coefficients
   localparam int COEF_FRAC     = 12;   // fractional bits of the cosine constants

   // Exact accumulator for sum(C*z); the butterfly adds one more bit.
   localparam int ACC_W     = IN_WORD_SIZE + COEF_FRAC + 3;
   localparam int SUM_W     = ACC_W + 1;
   // Largest ROM entry magnitude is 5572, so Q.COEF_FRAC plus sign fits.
   localparam int ROM_W     = COEF_FRAC + 2;
   localparam int CNT_W     = $clog2(IN_WORD_SIZE);
   localparam int RND_SHIFT = IN_FRAC + COEF_FRAC;

   localparam logic signed [SUM_W-1:0] RND_HALF = SUM_W'(2 ** (RND_SHIFT - 1));
   localparam logic signed [SUM_W-1:0] SAT_MAX  = SUM_W'(2 ** (OUT_WORD_SIZE - 1) - 1);
   localparam logic signed [SUM_W-1:0] SAT_MIN  = SUM_W'(-(2 ** (OUT_WORD_SIZE - 1)));

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // C(k,n) = round(c_k * cos((2n+1)k*pi/16) * 2^12), c_0 = sqrt(1/8), c_k = 1/2.
   // Only n = 0..3 is stored; outputs 7-n come from the butterfly.
   localparam int COS_TAB [8][4] = '{
      '{ 1448,  1448,  1448,  1448},   // k = 0
      '{ 2009,  1703,  1138,   400},   // k = 1
      '{ 1892,   784,  -784, -1892},   // k = 2
      '{ 1703,  -400, -2009, -1138},   // k = 3
      '{ 1448, -1448, -1448,  1448},   // k = 4
      '{ 1138, -2009,   400,  1703},   // k = 5
      '{  784, -1892,  1892,  -784},   // k = 6
      '{  400, -1138,  1703, -2009}    // k = 7
   };

   // Lanes 0..3 are E_0..E_3 (address bit j selects z(2j)),
   // lanes 4..7 are O_0..O_3 (address bit j selects z(2j+1)).
   function automatic logic signed [ROM_W-1:0] rom_entry(input int lane,
                                                          input logic [3:0] addr);
      int n;
      int odd;
      int s;
      n   = lane % 4;
      odd = lane / 4;
      s   = 0;
      for (int j = 0; j < 4; j++) begin
         if (addr[j]) s += COS_TAB[2 * j + odd][n];
      end
      return ROM_W'(s);
   endfunction

   // Round half up by the combined fraction, then clamp to the sample range.
   function automatic logic signed [OUT_WORD_SIZE-1:0] round_sat(
         input logic signed [SUM_W-1:0] v);
      logic signed [SUM_W-1:0] r;
      r = (v + RND_HALF) >>> RND_SHIFT;
      if (r > SAT_MAX)      r = SAT_MAX;
      else if (r < SAT_MIN) r = SAT_MIN;
      return OUT_WORD_SIZE'(r);
   endfunction

endpackage

// File: rtl/da_idct8_if.sv
// Coefficient-in / sample-out handshake bundle of the DA inverse DCT.
interface da_idct8_if;
   import da_idct_pkg::*;

   logic in_valid;
   logic in_ready;
   logic signed [IN_WORD_SIZE-1:0] z0, z1, z2, z3, z4, z5, z6, z7;
   logic out_valid;
   logic signed [OUT_WORD_SIZE-1:0] a0, a1, a2, a3, a4, a5, a6, a7;

   modport master (
      output in_valid, z0, z1, z2, z3, z4, z5, z6, z7,
      input  in_ready, out_valid, a0, a1, a2, a3, a4, a5, a6, a7
   );

   modport slave (
      input  in_valid, z0, z1, z2, z3, z4, z5, z6, z7,
      output in_ready, out_valid, a0, a1, a2, a3, a4, a5, a6, a7
   );

endinterface

// File: rtl/da_rom_lane.sv
// One DA lane: a 16-entry cosine-sum ROM feeding an MSB-first shift-add
// accumulator. The sign bit arrives first and is weighted negatively.
module da_rom_lane
   import da_idct_pkg::*;
#(
   parameter int LANE = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              addr,
   input  logic                    first,
   input  logic                    en,
   input  logic                    clr,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [ROM_W-1:0] rom_val;
   logic signed [ACC_W-1:0] rom_ext;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] acc_q;

   // Constant ROM lookup; folds to a small table per lane.
   always_comb begin
      rom_val = rom_entry(LANE, addr);
   end

   // Accumulate: negate on the sign bit, otherwise double and add.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      rom_ext = ACC_W'(rom_val);
      acc_d   = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = first ? -rom_ext : (acc_q <<< 1) + rom_ext;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
      if (!rst) acc_q <= '0;
      else      acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/da_idct8.sv
// Bit-serial distributed-arithmetic 8-point inverse DCT. Coefficients are
// captured into shift registers, fed MSB-first to eight DA lanes, and the
// lane sums are combined by an even/odd butterfly with rounding/saturation.
module da_idct8
   import da_idct_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   da_idct8_if.slave bus
);

   state_t                           state_q, state_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [IN_WORD_SIZE-1:0]          sh_q [8];
   logic [IN_WORD_SIZE-1:0]          sh_d [8];
   logic signed [OUT_WORD_SIZE-1:0]  a_q  [8];
   logic signed [OUT_WORD_SIZE-1:0]  a_d  [8];
   logic                             out_valid_q, out_valid_d;

   logic [IN_WORD_SIZE-1:0]          z_in [8];
   logic signed [ACC_W-1:0]          acc  [8];
   logic signed [OUT_WORD_SIZE-1:0]  bfly [8];
   logic [3:0]                       addr_e, addr_o;
   logic                             accept, lane_en, lane_first;

   assign z_in[0] = bus.z0;
   assign z_in[1] = bus.z1;
   assign z_in[2] = bus.z2;
   assign z_in[3] = bus.z3;
   assign z_in[4] = bus.z4;
   assign z_in[5] = bus.z5;
   assign z_in[6] = bus.z6;
   assign z_in[7] = bus.z7;

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.a0 = a_q[0];
   assign bus.a1 = a_q[1];
   assign bus.a2 = a_q[2];
   assign bus.a3 = a_q[3];
   assign bus.a4 = a_q[4];
   assign bus.a5 = a_q[5];
   assign bus.a6 = a_q[6];
   assign bus.a7 = a_q[7];

   assign accept     = bus.in_valid && (state_q == ST_IDLE);
   assign lane_en    = (state_q == ST_ACC);
   assign lane_first = (cnt_q == CNT_W'(IN_WORD_SIZE - 1));

   // Current bit of every coefficient, split into even and odd addresses.
   assign addr_e = {sh_q[6][IN_WORD_SIZE-1], sh_q[4][IN_WORD_SIZE-1],
                    sh_q[2][IN_WORD_SIZE-1], sh_q[0][IN_WORD_SIZE-1]};
   assign addr_o = {sh_q[7][IN_WORD_SIZE-1], sh_q[5][IN_WORD_SIZE-1],
                    sh_q[3][IN_WORD_SIZE-1], sh_q[1][IN_WORD_SIZE-1]};

   for (genvar g = 0; g < 8; g++) begin : g_lane
      da_rom_lane #(.LANE(g)) u_lane (
         .clk   (clk),
         .rst   (rst),
         .addr  ((g < 4) ? addr_e : addr_o),
         .first (lane_first),
         .en    (lane_en),
         .clr   (accept),
         .acc   (acc[g])
      );
   end

   // Butterfly: a[n] = E_n + O_n, a[7-n] = E_n - O_n, then round and clamp.
   always_comb begin
      for (int n = 0; n < 8; n++) bfly[n] = '0;
      for (int n = 0; n < 4; n++) begin
         bfly[n]     = round_sat(SUM_W'(acc[n]) + SUM_W'(acc[n + 4]));
         bfly[7 - n] = round_sat(SUM_W'(acc[n]) - SUM_W'(acc[n + 4]));
      end
   end

   // Next-state logic for the FSM, bit counter, shift registers and outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sh_d[i] = sh_q[i];
         a_d[i]  = a_q[i];
      end
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               for (int i = 0; i < 8; i++) sh_d[i] = z_in[i];
               cnt_d   = CNT_W'(IN_WORD_SIZE - 1);
               state_d = ST_ACC;
            end
         end
         ST_ACC: begin
            for (int i = 0; i < 8; i++) sh_d[i] = {sh_q[i][IN_WORD_SIZE-2:0], 1'b0};
            if (cnt_q == '0) state_d = ST_DONE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_DONE: begin
            for (int i = 0; i < 8; i++) a_d[i] = bfly[i];
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Register all control and datapath state; reset clears everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            sh_q[i] <= '0;
            a_q[i]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         for (int i = 0; i < 8; i++) begin
            sh_q[i] <= sh_d[i];
            a_q[i]  <= a_d[i];
         end
      end
   end

endmodule

// File: tb/tb_da_idct8.sv
// Self-checking bench for da_idct8: a floating-point reference IDCT with
// exact integer accumulation scores every result, while directed cases pin
// the model with hand-computed samples and check handshake timing.
module tb_da_idct8;
   import da_idct_pkg::*;

   typedef logic [7:0][IN_WORD_SIZE-1:0]  zvec_t;
   typedef logic [7:0][OUT_WORD_SIZE-1:0] avec_t;

   logic    clk = 1'b0;
   logic    rst = 1'b0;
   int      checks = 0;
   int      errors = 0;
   longint  cyc = 0;
   longint  accept_cyc = 0;
   avec_t   exp_q [$];
   longint  edge_q [$];

   da_idct8_if bif ();

   da_idct8 dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: a[n] = sum_k C(k,n)*z_k for all eight n, C from cos(),
   // then round half up and clamp.
   function automatic avec_t model(input zvec_t zv);
      avec_t  av;
      real    pi, ck, c;
      longint ci, s, r;
      pi = 3.14159265358979;
      for (int n = 0; n < 8; n++) begin
         s = 0;
         for (int k = 0; k < 8; k++) begin
            ck = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
            c  = ck * $cos(real'((2 * n + 1) * k) * pi / 16.0) * 4096.0;
            if (c >= 0.0) ci = longint'($floor(c + 0.5));
            else          ci = -longint'($floor(-c + 0.5));
            s += ci * longint'($signed(zv[k]));
         end
         r = (s + (longint'(1) <<< 23)) >>> 24;
         if (r > 511)  r = 511;
         if (r < -512) r = -512;
         av[n] = OUT_WORD_SIZE'(r);
      end
      return av;
   endfunction

   function automatic avec_t dut_a();
      avec_t av;
      av[0] = bif.a0; av[1] = bif.a1; av[2] = bif.a2; av[3] = bif.a3;
      av[4] = bif.a4; av[5] = bif.a5; av[6] = bif.a6; av[7] = bif.a7;
      return av;
   endfunction

   function automatic zvec_t mk2(input int v0, input int v1);
      zvec_t zv;
      zv    = '0;
      zv[0] = IN_WORD_SIZE'(v0);
      zv[1] = IN_WORD_SIZE'(v1);
      return zv;
   endfunction

   task automatic drive(input zvec_t zv);
      bif.z0 = zv[0]; bif.z1 = zv[1]; bif.z2 = zv[2]; bif.z3 = zv[3];
      bif.z4 = zv[4]; bif.z5 = zv[5]; bif.z6 = zv[6]; bif.z7 = zv[7];
   endtask

   // Scoreboard: queue the model result at each accept, compare on out_valid.
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         edge_q.delete();
      end else begin
         if (bif.out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", 1, 0);
            end else begin
               automatic avec_t  ev = exp_q.pop_front();
               automatic longint ae = edge_q.pop_front();
               automatic avec_t  gv = dut_a();
               check("model_latency", cyc - ae, IN_WORD_SIZE + 1);
               for (int n = 0; n < 8; n++)
                  check($sformatf("model_a%0d", n), $signed(gv[n]), $signed(ev[n]));
            end
         end
         if (bif.in_valid && bif.in_ready) begin
            exp_q.push_back(model({bif.z7, bif.z6, bif.z5, bif.z4,
                                   bif.z3, bif.z2, bif.z1, bif.z0}));
            edge_q.push_back(cyc + 1);
         end
      end
   end

   task automatic send(input zvec_t zv);
      int w;
      @(posedge clk); #1;
      drive(zv);
      bif.in_valid = 1'b1;
      w = 0;
      while (!bif.in_ready && w < 60) begin
         @(negedge clk);
         w++;
      end
      if (w >= 60) check("send_timeout", 0, 1);
      @(posedge clk); #1;
      accept_cyc   = cyc;
      bif.in_valid = 1'b0;
   endtask

   task automatic wait_result(output avec_t got);
      int w;
      w = 0;
      @(negedge clk);
      while (!bif.out_valid && w < 60) begin
         @(negedge clk);
         w++;
      end
      check("result_seen", bif.out_valid, 1);
      check("latency", cyc - accept_cyc, 27);
      got = dut_a();
   endtask

   task automatic expect_all(input string name, input avec_t got, input int v);
      for (int n = 0; n < 8; n++)
         check($sformatf("%s_a%0d", name, n), $signed(got[n]), v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      automatic int    exp1 [8] = '{49, 42, 28, 10, -10, -28, -42, -49};
      automatic avec_t got;
      automatic zvec_t zv;
      automatic longint e1, e2;
      automatic int    low, pulses;

      bif.in_valid = 1'b0;
      drive('0);

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", bif.out_valid, 0);
      check("rst_in_ready", bif.in_ready, 1);
      check("rst_a0", $signed(bif.a0), 0);
      rst = 1'b1;
      @(negedge clk);
      check("rel_in_ready", bif.in_ready, 1);

      // DC, negative DC, single odd coefficient.
      send(mk2(1158524, 0));
      wait_result(got);
      expect_all("dc", got, 100);
      send(mk2(-1158524, 0));
      wait_result(got);
      expect_all("ndc", got, -100);
      send(mk2(0, 409600));
      wait_result(got);
      for (int n = 0; n < 8; n++)
         check($sformatf("z1_a%0d", n), $signed(got[n]), exp1[n]);

      // Saturation and extreme coefficients.
      send(mk2((1 << 25) - 1, 0));
      wait_result(got);
      expect_all("satp", got, 511);
      send(mk2(-(1 << 25), 0));
      wait_result(got);
      expect_all("satn", got, -512);
      send(mk2(0, 0));
      wait_result(got);
      expect_all("zero", got, 0);

      // Mixed vectors exercising every lane, scored by the model.
      zv = '0;
      zv[0] = IN_WORD_SIZE'(500000);  zv[1] = IN_WORD_SIZE'(-120000);
      zv[2] = IN_WORD_SIZE'(80000);   zv[3] = IN_WORD_SIZE'(-60000);
      zv[4] = IN_WORD_SIZE'(40000);   zv[5] = IN_WORD_SIZE'(-30000);
      zv[6] = IN_WORD_SIZE'(20000);   zv[7] = IN_WORD_SIZE'(-10000);
      send(zv);
      wait_result(got);
      zv[0] = IN_WORD_SIZE'(-300000); zv[1] = IN_WORD_SIZE'(250000);
      zv[2] = IN_WORD_SIZE'(-200000); zv[3] = IN_WORD_SIZE'(150000);
      zv[4] = IN_WORD_SIZE'(123456);  zv[5] = IN_WORD_SIZE'(-98765);
      zv[6] = IN_WORD_SIZE'(77777);   zv[7] = IN_WORD_SIZE'(-55555);
      send(zv);
      wait_result(got);
      zv[5] = IN_WORD_SIZE'(-(1 << 25)); zv[6] = IN_WORD_SIZE'(1 << 24);
      send(zv);
      wait_result(got);

      // Back-to-back with in_valid held high.
      @(posedge clk); #1;
      drive(mk2(1158524, 0));
      bif.in_valid = 1'b1;
      @(posedge clk); #1;
      e1 = cyc;
      drive(mk2(0, 409600));
      low = 0;
      @(negedge clk);
      while (!bif.in_ready && low < 60) begin
         low++;
         @(negedge clk);
      end
      check("b2b_busy_cycles", low, 27);
      check("b2b_first_valid", bif.out_valid, 1);
      check("b2b_first_a0", $signed(bif.a0), 100);
      @(posedge clk); #1;
      e2 = cyc;
      bif.in_valid = 1'b0;
      accept_cyc   = e2;
      check("b2b_spacing", e2 - e1, 28);
      wait_result(got);
      for (int n = 0; n < 8; n++)
         check($sformatf("b2b_z1_a%0d", n), $signed(got[n]), exp1[n]);

      // Reset in the middle of accumulation.
      send(mk2(1158524, 0));
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      for (int n = 0; n < 8; n++) check($sformatf("abort_a%0d", n), $signed(got[n]) * 0 + $signed(dut_a()[n]), 0);
      check("abort_out_valid", bif.out_valid, 0);
      check("abort_in_ready", bif.in_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (bif.out_valid) pulses++;
      end
      check("abort_no_pulse", pulses, 0);
      check("abort_idle", bif.in_ready, 1);
      send(mk2(1158524, 0));
      wait_result(got);
      expect_all("post_abort_dc", got, 100);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
